// File: rtl/mips_pkg.sv
// Shared pipeline encodings and helpers for the decode-stage hazard logic.
package mips_pkg;

    // Tuse: cycles until a source operand is consumed, counted from D.
    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    // Tnew: cycles after entering E until the result can be forwarded.
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Default multiply/divide unit occupancy after the op enters E.
    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Producer tracked in the E stage.
    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } e_slot_t;

    // Producer tracked in the M stage.
    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tnew;
    } m_slot_t;

    // One stage of progress towards forwardability, floored at zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // A source must wait if an in-flight producer of that register will not
    // have its result ready by the time the consumer needs it. $0 is never a
    // real dependency.
    function automatic logic src_hazard(
        input logic       use_src,
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dest_e,
        input logic [1:0] tnew_e,
        input logic [4:0] dest_m,
        input logic [1:0] tnew_m
    );
        return use_src && (src != REG_ZERO) &&
               (((src == dest_e) && (tnew_e > tuse)) ||
                ((src == dest_m) && (tnew_m > tuse)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Occupancy counter of the multiply/divide unit: loaded when an md op sits
// in E, then counts down to idle.
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = 4              // must be wide enough for DIV_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    input  logic div_e,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] busy_cnt;

    // Load on a new md op, otherwise count down to zero and stay there.
    // NOTE: state is assigned with <= so every flop samples pre-edge values;
    // reset is synchronous, so it is only tested inside the clocked branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (md_start_e) begin
            busy_cnt <= div_e ? DIV_LOAD : MULT_LOAD;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_ONE;
        end
    end

    assign busy = (busy_cnt != '0);

    // The md hazard holds any md op in D while the unit is occupied, so a
    // load can only ever happen from idle.
    assert property (@(posedge clk) disable iff (reset)
                     md_start_e |-> (busy_cnt == '0))
        else $error("md_busy_counter: md op started while unit busy");

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: tracks E/M producers and MD unit
// occupancy, and freezes F/D while bubbling D/E when D must wait.
module hazard_stall_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       use_rs_d,
    input  logic       use_rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dest_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall,
    output logic       clr_de
);

    e_slot_t e_slot;
    m_slot_t m_slot;
    logic    md_busy;
    logic    rs_hazard;
    logic    rt_hazard;
    logic    md_hazard;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy (
        .clk        (clk),
        .reset      (reset),
        .md_start_e (e_slot.md_start),
        .div_e      (e_slot.md_div),
        .busy       (md_busy)
    );

    // Hazard detection for the instruction currently in D.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        md_hazard = 1'b0;
        rs_hazard = src_hazard(use_rs_d, rs_d, tuse_rs_d,
                               e_slot.dest, e_slot.tnew, m_slot.dest, m_slot.tnew);
        rt_hazard = src_hazard(use_rt_d, rt_d, tuse_rt_d,
                               e_slot.dest, e_slot.tnew, m_slot.dest, m_slot.tnew);
        md_hazard = md_use_d && (e_slot.md_start || md_busy);
    end

    // D/E has its own reset, so no bubble is requested while in reset.
    assign stall  = !reset && (rs_hazard || rt_hazard || md_hazard);
    assign clr_de = stall;

    // Shadow of the E and M producers; a stall pushes a bubble into E.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot <= '0;
            m_slot <= '0;
        end else begin
            m_slot <= '{dest: e_slot.dest, tnew: sat_dec(e_slot.tnew)};
            if (stall) begin
                e_slot <= '0;
            end else begin
                e_slot <= '{dest:     dest_d,
                            tnew:     tnew_d,
                            md_start: md_start_d,
                            md_div:   md_start_d && md_div_d};
            end
        end
    end

endmodule
